program_loader: RTL
===================

# program_loader

Writes programs into the CPU's instruction memory. Accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words, and drives the memory write port. Holds the CPU in reset while a load is in progress. Sits between a host byte source (UART receiver or testbench) and the write side of `MEMORY`, whose read side the `CPU` fetches from.

## Interface
- `PC_WIDTH`, 4: instruction-memory address width; capacity is 2^PC_WIDTH words.
- `INSTRUCTION_WIDTH`, 13: instruction word width; legal range 9..16.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `byteIn` in 8: incoming stream byte.
- `byteValid` in 1: `byteIn` is valid.
- `byteReady` out 1: loader accepts a byte this cycle.
- `writeEnable` out 1: instruction-memory write strobe, one cycle per word.
- `writeAddress` out PC_WIDTH: write address.
- `writeData` out INSTRUCTION_WIDTH: write data.
- `cpuHold` out 1: drives CPU reset; high means the CPU is held.
- `loadDone` out 1: one-cycle pulse when a load completes successfully.
- `loadError` out 1: sticky checksum-failure flag.

## Operation
- Byte accepted at a rising edge where `byteValid && byteReady`.
- Stream format:
  - Count byte N: the low PC_WIDTH bits are used and higher bits are ignored; N==0 means 2^PC_WIDTH.
  - Then N instructions, each sent as two bytes, low byte first.
  - The word is {high[INSTRUCTION_WIDTH-9:0], low}; unused high bits are discarded.
- FSM states:
  - IDLE: waits for the count byte, then goes to LOW.
  - LOW: accepts the low byte, then goes to HIGH.
  - HIGH: accepts the high byte and schedules a write. Goes to LOW if more words remain; otherwise goes to CHECK (macro on) or DONE (macro off).
  - CHECK: accepts the checksum byte. Goes to DONE on match, ERROR on mismatch.
  - DONE: lasts one cycle, then returns to IDLE.
  - ERROR: terminal until `reset`.
- `byteReady` = 1 in IDLE, LOW, HIGH and CHECK; 0 in DONE and ERROR.
- Word index starts at 0 when the count byte is accepted. Word i is written to address i. The index increments after each write. The final write is at address N-1; with N==2^PC_WIDTH the final address is all-ones with no wrap.
- `cpuHold`:
  - 1 from reset until the first successful load.
  - Goes to 1 the cycle after any count byte is accepted; a reload re-holds the CPU.
  - Goes to 0 on entry to IDLE from DONE.
  - Stays 1 in ERROR.
- Reset values:
  - State IDLE, `byteReady`=1 (combinational from state), `cpuHold`=1.
  - `writeEnable`=0, `writeAddress`=0, `writeData`=0.
  - `loadDone`=0, `loadError`=0, index 0, checksum 0.
- Reset during a load: returns to IDLE immediately. Words already written stay in memory. `cpuHold` stays 1.

## Timing
- `writeEnable`, `writeAddress` and `writeData` are registered. High byte accepted at edge k → write strobe during cycle k..k+1 → memory captures at edge k+1.
- Back-to-back bytes are accepted at full rate: one byte per cycle, with no bubble around writes.
- Macro off: last high byte accepted at edge k.
  - Cycle after k: last `writeEnable`=1, state DONE, `loadDone`=1, `cpuHold`=1.
  - Cycle after k+1: IDLE, `cpuHold`=0.
  - The CPU is released only after the last word is committed.
- Macro on: checksum byte accepted at edge k.
  - Match: DONE during cycle after k, with `loadDone`=1.
  - Mismatch: ERROR, with `loadError`=1 from cycle after k, sticky.
- `byteValid` held while `byteReady`=0 (DONE or ERROR): no acceptance occurs and the byte is not lost by the source.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - A trailing checksum byte follows the instructions. It must equal the XOR of all 2N instruction bytes; the count byte is excluded.
  - CHECK and ERROR states exist.
- Undefined:
  - No checksum byte; HIGH goes directly to DONE.
  - `loadError` is tied to 0. The CHECK and ERROR states and the checksum register are not synthesized.

## Structure
- Shared package `puc_pkg`:
  - FSM state typedef `loader_state_t`.
  - `BYTE_WIDTH`=8.
  - `PC_WIDTH` and `INSTRUCTION_WIDTH` defaults, shared with the CPU parameters.
- Sub-module `loader_checksum`: running XOR register with clear-on-count-byte and update-on-accept. It is instantiated only under `LOADER_CHECKSUM_EN`.

## Test plan
- Reset, then stream 0x02, 0x05,0x03, 0x01,0x04 (macro off) → writes addr0=0x305, addr1=0x401. `loadDone` pulses in the same cycle as the second write. `cpuHold` falls one cycle later.
- Count 0x00 followed by 32 bytes → 16 writes, addresses 0..15. The last write is at address 15 with no wrap. `cpuHold` stays 1 until DONE exits.
- High byte 0xFF with INSTRUCTION_WIDTH=13 → only bits [4:0] are kept. Low byte 0x00 gives `writeData`=0x1F00.
- Macro on, stream 0x01,0xAA,0x02,checksum 0xA8 → write addr0=0x2AA and `loadDone`. Same stream with checksum 0x00 → `loadError`=1, `byteReady`=0, `cpuHold`=1 held until reset.
- Assert `reset` after 3 of 4 instruction bytes → IDLE next cycle; addr0 already written and unchanged. A new full load then succeeds.
- A reload after a completed load → `cpuHold` rises the cycle after the count byte is accepted.

Source files
------------

// File: rtl/puc_pkg.sv
// Shared definitions for the program loader and the CPU it feeds:
// byte width, default memory/instruction geometry and the loader FSM states.
package puc_pkg;

    localparam int BYTE_WIDTH                = 8;
    localparam int DEFAULT_PC_WIDTH          = 4;
    localparam int DEFAULT_INSTRUCTION_WIDTH = 13;

    // ST_CHECK and ST_ERROR are only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOW   = 3'd1,
        ST_HIGH  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Running XOR of the instruction bytes of one load. Cleared when a count
// byte is accepted, updated on every accepted instruction byte.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_checksum
    import puc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  update,
    input  logic [BYTE_WIDTH-1:0] byteIn,
    output logic [BYTE_WIDTH-1:0] checksum
);

    // XOR accumulator; clear takes priority over update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (clear) begin
            checksum <= '0;
        end else if (update) begin
            checksum <= checksum ^ byteIn;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: takes a byte stream (count, then low/high byte pairs),
// writes assembled instruction words into instruction memory and holds the
// CPU in reset while a load is in progress.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte, the CHECK/ERROR states and the sticky loadError flag.
//
// Handshake: a byte is transferred at a rising clock edge where
// byteValid && byteReady. byteReady depends only on the current state, so
// the source may hold byteValid/byteIn steady while byteReady is low and
// nothing is consumed.
module program_loader
    import puc_pkg::*;
#(
    parameter int PC_WIDTH          = DEFAULT_PC_WIDTH,
    // Legal range 9..16: the high byte contributes INSTRUCTION_WIDTH-8 bits.
    parameter int INSTRUCTION_WIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [BYTE_WIDTH-1:0]        byteIn,
    input  logic                         byteValid,
    output logic                         byteReady,
    output logic                         writeEnable,
    output logic [PC_WIDTH-1:0]          writeAddress,
    output logic [INSTRUCTION_WIDTH-1:0] writeData,
    output logic                         cpuHold,
    output logic                         loadDone,
    output logic                         loadError,
    output loader_state_t                debugState
);

    loader_state_t           state;
    logic [PC_WIDTH-1:0]     index;
    logic [PC_WIDTH-1:0]     lastIndex;
    logic [BYTE_WIDTH-1:0]   lowByte;
    logic                    accept;
    logic                    lastWord;

    assign byteReady  = (state == ST_IDLE) || (state == ST_LOW) ||
                        (state == ST_HIGH) || (state == ST_CHECK);
    assign accept     = byteValid && byteReady;
    // lastIndex = N-1 modulo 2^PC_WIDTH, so a count of 0 (meaning a full
    // memory) naturally gives an all-ones final address with no wrap.
    assign lastWord   = (index == lastIndex);
    assign debugState = state;

`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] checksum;
    logic                  checksumClear;
    logic                  checksumUpdate;
    logic                  loadErrorReg;

    assign checksumClear  = accept && (state == ST_IDLE);
    assign checksumUpdate = accept && ((state == ST_LOW) || (state == ST_HIGH));
    assign loadError      = loadErrorReg;

    loader_checksum u_checksum (
        .clock    (clock),
        .reset    (reset),
        .clear    (checksumClear),
        .update   (checksumUpdate),
        .byteIn   (byteIn),
        .checksum (checksum)
    );
`else
    assign loadError = 1'b0;
`endif

    // Loader FSM with registered write port, CPU hold and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            index        <= '0;
            lastIndex    <= '0;
            lowByte      <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            writeData    <= '0;
            cpuHold      <= 1'b1;
            loadDone     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            loadErrorReg <= 1'b0;
`endif
        end else begin
            writeEnable <= 1'b0;
            loadDone    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lastIndex <= byteIn[PC_WIDTH-1:0] - PC_WIDTH'(1);
                        index     <= '0;
                        cpuHold   <= 1'b1;
                        state     <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (accept) begin
                        lowByte <= byteIn;
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (accept) begin
                        writeEnable  <= 1'b1;
                        writeAddress <= index;
                        writeData    <= {byteIn[INSTRUCTION_WIDTH-9:0], lowByte};
                        if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= ST_CHECK;
`else
                            state    <= ST_DONE;
                            loadDone <= 1'b1;
`endif
                        end else begin
                            index <= index + PC_WIDTH'(1);
                            state <= ST_LOW;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        if (byteIn == checksum) begin
                            state    <= ST_DONE;
                            loadDone <= 1'b1;
                        end else begin
                            state        <= ST_ERROR;
                            loadErrorReg <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
`endif
                ST_DONE: begin
                    cpuHold <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
